// File: rtl/twi_frame_capture.sv
// rtl/twi_frame_capture.sv - passive TWI sniffer capturing the first 18 bits after each START
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   enable          low: FSM, bit counter and shift register hold; pin sampling keeps running
//   scl, sda        raw asynchronous bus pins
//   TX_available    downstream presenter can accept a frame (only looked at in HAND)
//   frame[17:0]     {addr[7:0], ack0, data[7:0], ack1}, held until the next accepted frame
//   new_data_ready  one-cycle pulse when frame is updated
//   frame_dropped   one-cycle pulse when a complete frame was discarded
//   bus_active      high from detected START until detected STOP
//
// Build option: TWI_GLITCH_FILTER_EN adds a 3-sample stability filter on each pin.

module twi_frame_capture (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        scl,
  input  logic        sda,
  input  logic        TX_available,
  output logic [17:0] frame,
  output logic        new_data_ready,
  output logic        frame_dropped,
  output logic        bus_active
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SHIFT     = 2'd1,
    HAND      = 2'd2,
    WAIT_STOP = 2'd3
  } state_t;

  localparam logic [4:0] FRAME_BITS = 5'd18;

  // Pin conditioning: two synchronizer flops, a "cur" stage and a history stage.
  logic scl_s1, scl_s2, scl_cur, scl_prev;
  logic sda_s1, sda_s2, sda_cur, sda_prev;

`ifdef TWI_GLITCH_FILTER_EN
  // Delayed copies of the synchronized samples; cur only follows s2 when
  // the last three synchronized samples agree.
  logic scl_h0, scl_h1, sda_h0, sda_h1;

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_h0 <= 1'b1;
      scl_h1 <= 1'b1;
      sda_h0 <= 1'b1;
      sda_h1 <= 1'b1;
      scl_cur <= 1'b1;
      sda_cur <= 1'b1;
    end else begin
      scl_h0 <= scl_s2;
      scl_h1 <= scl_h0;
      sda_h0 <= sda_s2;
      sda_h1 <= sda_h0;
      if ((scl_s2 == scl_h0) && (scl_h0 == scl_h1)) begin
        scl_cur <= scl_s2;
      end
      if ((sda_s2 == sda_h0) && (sda_h0 == sda_h1)) begin
        sda_cur <= sda_s2;
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_cur <= 1'b1;
      sda_cur <= 1'b1;
    end else begin
      scl_cur <= scl_s2;
      sda_cur <= sda_s2;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_s1   <= 1'b1;
      scl_s2   <= 1'b1;
      scl_prev <= 1'b1;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_s1   <= scl;
      scl_s2   <= scl_s1;
      scl_prev <= scl_cur;
      sda_s1   <= sda;
      sda_s2   <= sda_s1;
      sda_prev <= sda_cur;
    end
  end

  // Bus events; START and STOP are mutually exclusive and neither can
  // coincide with an SCL rise, since those need prev SCL = 1 vs 0.
  logic scl_rise, start_det, stop_det;

  assign scl_rise  = ~scl_prev & scl_cur;
  assign start_det = scl_prev & scl_cur &  sda_prev & ~sda_cur;
  assign stop_det  = scl_prev & scl_cur & ~sda_prev &  sda_cur;

  // Capture state
  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [17:0] shreg_q, shreg_d;
  logic [17:0] frame_q, frame_d;
  logic        bus_q, bus_d;
  logic        hand_go;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      shreg_q <= 18'h0;
      frame_q <= 18'h0;
      bus_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      frame_q <= frame_d;
      bus_q   <= bus_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    frame_d = frame_q;
    bus_d   = bus_q;

    if (enable) begin
      if (start_det) begin
        bus_d = 1'b1;
      end else if (stop_det) begin
        bus_d = 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start_det) begin
            state_d = SHIFT;
            cnt_d   = 5'd0;
          end
        end

        SHIFT: begin
          if (stop_det) begin
            state_d = IDLE;
          end else if (start_det) begin
            cnt_d = 5'd0;
          end else if (scl_rise) begin
            shreg_d = {shreg_q[16:0], sda_cur};
            cnt_d   = (cnt_q == 5'd31) ? cnt_q : cnt_q + 5'd1;
            if (cnt_d == FRAME_BITS) begin
              state_d = HAND;
            end
          end
        end

        HAND: begin
          // Handoff first, then any START/STOP seen this same cycle.
          if (TX_available) begin
            frame_d = shreg_q;
          end
          state_d = WAIT_STOP;
          if (stop_det) begin
            state_d = IDLE;
          end else if (start_det) begin
            state_d = SHIFT;
            cnt_d   = 5'd0;
          end
        end

        WAIT_STOP: begin
          if (stop_det) begin
            state_d = IDLE;
          end else if (start_det) begin
            state_d = SHIFT;
            cnt_d   = 5'd0;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // The handoff is visible in the HAND cycle itself: frame shows the shift
  // register during the pulse and frame_q holds it from the next cycle on.
  assign hand_go        = (state_q == HAND) && enable;
  assign new_data_ready = hand_go & TX_available;
  assign frame_dropped  = hand_go & ~TX_available;
  assign frame          = new_data_ready ? shreg_q : frame_q;
  assign bus_active     = bus_q;

endmodule
